// File: rtl/cpu_hazard_pkg.sv
// Shared types and stage/PC-increment constants for the hazard unit.
`ifndef CPU_HAZARD_DEFINES
`define CPU_HAZARD_DEFINES
`define HAZARD_STALL_IF  0
`define HAZARD_STALL_ID  1
`define HAZARD_STALL_EX  2
`define HAZARD_STALL_MEM 3
`define HAZARD_STALL_WB  4
`define HAZARD_FLUSH_IF  0
`define HAZARD_FLUSH_ID  1
`define HAZARD_FLUSH_EX  2
`define HAZARD_FLUSH_MEM 3
`define HAZARD_FLUSH_WB  4
`define PC_INC_NORMAL    2'b00
`define PC_INC_BRANCH    2'b01
`define PC_INC_JUMP      2'b10
`endif

package cpu_hazard_pkg;
   localparam int HAZARD_STAGE_N = 5;

   typedef enum logic [1:0] {
      FWD_REGFILE = 2'b00,
      FWD_EX      = 2'b01,
      FWD_MEM     = 2'b10,
      FWD_WB      = 2'b11
   } fwd_sel_t;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } hz_state_t;
endpackage

// File: rtl/cpu_sat_counter.sv
// Saturating event counter with sync clear and freeze.
module cpu_sat_counter #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               freeze,
   input  logic               inc,
   output logic [COUNT_W-1:0] count
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (!freeze && inc && (count != {COUNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end
endmodule

// File: rtl/cpu_hazard_forward_unit.sv
// RAW hazard detection, forwarding select, redirect flush sequencing
// and performance counters for the 5-stage pipeline.
module cpu_hazard_forward_unit
   import cpu_hazard_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int COUNT_W     = 32,
   parameter int FORWARD_EN  = 1,
   parameter int FLUSH_DEPTH = 1
) (
   input  logic                  clk,
   input  logic                  clr_n,
   input  logic                  cnt_clr,
   input  logic                  cnt_freeze,
   input  logic [REG_ADDR_W-1:0] id_rs_num,
   input  logic [REG_ADDR_W-1:0] id_rt_num,
   input  logic                  id_rs_used,
   input  logic                  id_rt_used,
   input  logic [REG_ADDR_W-1:0] ex_wr_num,
   input  logic [REG_ADDR_W-1:0] mem_wr_num,
   input  logic [REG_ADDR_W-1:0] wb_wr_num,
   input  logic                  ex_is_load,
   input  logic [1:0]            ex_pc_inc,
   output logic [HAZARD_STAGE_N-1:0] stalls,
   output logic [HAZARD_STAGE_N-1:0] flushs,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic [COUNT_W-1:0]    data_hazard_count,
   output logic [COUNT_W-1:0]    data_hazard_ex_count,
   output logic [COUNT_W-1:0]    data_hazard_mem_count,
   output logic [COUNT_W-1:0]    load_use_count,
   output logic [COUNT_W-1:0]    forward_count,
   output logic [COUNT_W-1:0]    control_hazard_count,
   output logic [COUNT_W-1:0]    control_hazard_branch_count,
   output logic [COUNT_W-1:0]    control_hazard_jump_count,
   output logic [COUNT_W-1:0]    stall_cycle_count
);
   localparam logic [1:0] FL_LOAD = 2'(FLUSH_DEPTH - 1);
   localparam int         N_CNT   = 9;

   hz_state_t  state, state_nx;
   logic [1:0] fl_cnt, fl_cnt_nx;

   logic rs_ex, rs_mem, rs_wb, rt_ex, rt_mem, rt_wb;
   logic ctrl, active, load_use, data_stall, ex_hit, mem_hit;
   logic is_br, is_jmp;
   fwd_sel_t sel_a, sel_b;
   logic [N_CNT-1:0] inc;
   logic [COUNT_W-1:0] cnt [N_CNT];

   function automatic fwd_sel_t pick(input logic ex, mem, wb);
      priority case (1'b1)
         ex:      pick = FWD_EX;
         mem:     pick = FWD_MEM;
         wb:      pick = FWD_WB;
         default: pick = FWD_REGFILE;
      endcase
   endfunction

   assign rs_ex  = id_rs_used && (id_rs_num != '0) && (id_rs_num == ex_wr_num);
   assign rs_mem = id_rs_used && (id_rs_num != '0) && (id_rs_num == mem_wr_num);
   assign rs_wb  = id_rs_used && (id_rs_num != '0) && (id_rs_num == wb_wr_num);
   assign rt_ex  = id_rt_used && (id_rt_num != '0) && (id_rt_num == ex_wr_num);
   assign rt_mem = id_rt_used && (id_rt_num != '0) && (id_rt_num == mem_wr_num);
   assign rt_wb  = id_rt_used && (id_rt_num != '0) && (id_rt_num == wb_wr_num);

   assign is_br  = (ex_pc_inc == `PC_INC_BRANCH);
   assign is_jmp = (ex_pc_inc == `PC_INC_JUMP);
   assign ex_hit  = rs_ex | rt_ex;
   assign mem_hit = rs_mem | rt_mem;

   // Redirects are only honoured in RUN; FLUSH masks everything in ID.
   always_comb begin
      ctrl       = (state == ST_RUN) && (is_br || is_jmp);
      active     = (state == ST_RUN) && !ctrl;
      load_use   = 1'b0;
      data_stall = 1'b0;
      sel_a      = FWD_REGFILE;
      sel_b      = FWD_REGFILE;
      if (FORWARD_EN != 0) begin
         load_use   = active && ex_hit && ex_is_load;
         data_stall = load_use;
         if (active && !load_use) begin
            sel_a = pick(rs_ex, rs_mem, rs_wb);
            sel_b = pick(rt_ex, rt_mem, rt_wb);
         end
      end else begin
         data_stall = active && (ex_hit || mem_hit);
      end
   end

   assign fwd_a = sel_a;
   assign fwd_b = sel_b;

   always_comb begin
      stalls = '0;
      flushs = '0;
      stalls[`HAZARD_STALL_IF] = data_stall;
      stalls[`HAZARD_STALL_ID] = data_stall;
      flushs[`HAZARD_FLUSH_EX] = data_stall || ctrl;
      flushs[`HAZARD_FLUSH_ID] = ctrl || (state == ST_FLUSH);
   end

   always_comb begin
      state_nx  = state;
      fl_cnt_nx = fl_cnt;
      unique case (state)
         ST_RUN: begin
            if (ctrl && (FLUSH_DEPTH > 1)) begin
               state_nx  = ST_FLUSH;
               fl_cnt_nx = FL_LOAD;
            end
         end
         ST_FLUSH: begin
            if (fl_cnt <= 2'd1) begin
               state_nx  = ST_RUN;
               fl_cnt_nx = '0;
            end else begin
               fl_cnt_nx = fl_cnt - 2'd1;
            end
         end
         default: state_nx = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state  <= ST_RUN;
         fl_cnt <= '0;
      end else begin
         state  <= state_nx;
         fl_cnt <= fl_cnt_nx;
      end
   end

   assign inc[0] = data_stall;
   assign inc[1] = data_stall && ex_hit;
   assign inc[2] = data_stall && !ex_hit;
   assign inc[3] = load_use;
   assign inc[4] = (sel_a != FWD_REGFILE) || (sel_b != FWD_REGFILE);
   assign inc[5] = ctrl;
   assign inc[6] = ctrl && is_br;
   assign inc[7] = ctrl && is_jmp;
   assign inc[8] = stalls[`HAZARD_STALL_ID];

   for (genvar i = 0; i < N_CNT; i++) begin : g_cnt
      cpu_sat_counter #(.COUNT_W(COUNT_W)) u_cnt (
         .clk    (clk),
         .rst_n  (clr_n),
         .clr    (cnt_clr),
         .freeze (cnt_freeze),
         .inc    (inc[i]),
         .count  (cnt[i])
      );
   end

   assign data_hazard_count           = cnt[0];
   assign data_hazard_ex_count        = cnt[1];
   assign data_hazard_mem_count       = cnt[2];
   assign load_use_count              = cnt[3];
   assign forward_count               = cnt[4];
   assign control_hazard_count        = cnt[5];
   assign control_hazard_branch_count = cnt[6];
   assign control_hazard_jump_count   = cnt[7];
   assign stall_cycle_count           = cnt[8];
endmodule

// File: tb/tb_cpu_hazard_forward_unit.sv
// Directed bench: instance A (forwarding, depth 1, 4-bit counters)
// and instance B (no forwarding, depth 3, 32-bit counters).
module tb_cpu_hazard_forward_unit;
   localparam logic [1:0] PC_NRM = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   logic       clk, clr_n, cnt_clr, cnt_freeze;
   logic [4:0] rs, rt, ex_wr, mem_wr, wb_wr;
   logic       rs_used, rt_used, ex_is_load;
   logic [1:0] pc_inc;

   logic [4:0]  a_stalls, a_flushs, b_stalls, b_flushs;
   logic [1:0]  a_fa, a_fb, b_fa, b_fb;
   logic [3:0]  a_cnt [9];
   logic [31:0] b_cnt [9];

   int total = 0;
   int bad = 0;

   cpu_hazard_forward_unit #(
      .REG_ADDR_W(5), .COUNT_W(4), .FORWARD_EN(1), .FLUSH_DEPTH(1)
   ) u_a (
      .clk(clk), .clr_n(clr_n), .cnt_clr(cnt_clr), .cnt_freeze(cnt_freeze),
      .id_rs_num(rs), .id_rt_num(rt), .id_rs_used(rs_used), .id_rt_used(rt_used),
      .ex_wr_num(ex_wr), .mem_wr_num(mem_wr), .wb_wr_num(wb_wr),
      .ex_is_load(ex_is_load), .ex_pc_inc(pc_inc),
      .stalls(a_stalls), .flushs(a_flushs), .fwd_a(a_fa), .fwd_b(a_fb),
      .data_hazard_count(a_cnt[0]), .data_hazard_ex_count(a_cnt[1]),
      .data_hazard_mem_count(a_cnt[2]), .load_use_count(a_cnt[3]),
      .forward_count(a_cnt[4]), .control_hazard_count(a_cnt[5]),
      .control_hazard_branch_count(a_cnt[6]),
      .control_hazard_jump_count(a_cnt[7]), .stall_cycle_count(a_cnt[8])
   );

   cpu_hazard_forward_unit #(
      .REG_ADDR_W(5), .COUNT_W(32), .FORWARD_EN(0), .FLUSH_DEPTH(3)
   ) u_b (
      .clk(clk), .clr_n(clr_n), .cnt_clr(cnt_clr), .cnt_freeze(cnt_freeze),
      .id_rs_num(rs), .id_rt_num(rt), .id_rs_used(rs_used), .id_rt_used(rt_used),
      .ex_wr_num(ex_wr), .mem_wr_num(mem_wr), .wb_wr_num(wb_wr),
      .ex_is_load(ex_is_load), .ex_pc_inc(pc_inc),
      .stalls(b_stalls), .flushs(b_flushs), .fwd_a(b_fa), .fwd_b(b_fb),
      .data_hazard_count(b_cnt[0]), .data_hazard_ex_count(b_cnt[1]),
      .data_hazard_mem_count(b_cnt[2]), .load_use_count(b_cnt[3]),
      .forward_count(b_cnt[4]), .control_hazard_count(b_cnt[5]),
      .control_hazard_branch_count(b_cnt[6]),
      .control_hazard_jump_count(b_cnt[7]), .stall_cycle_count(b_cnt[8])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs = 0; rt = 0; rs_used = 0; rt_used = 0;
      ex_wr = 0; mem_wr = 0; wb_wr = 0;
      ex_is_load = 0; pc_inc = PC_NRM;
   endtask

   initial begin
      clr_n = 0; cnt_clr = 0; cnt_freeze = 0;
      idle();
      #3;
      chk("rst_a_stalls", 32'(a_stalls), 0);
      chk("rst_a_flushs", 32'(a_flushs), 0);
      chk("rst_b_flushs", 32'(b_flushs), 0);
      chk("rst_a_fwd", 32'({a_fa, a_fb}), 0);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("rst_a_cnt%0d", i), 32'(a_cnt[i]), 0);
         chk($sformatf("rst_b_cnt%0d", i), b_cnt[i], 0);
      end
      tick();
      clr_n = 1;
      tick();

      // EX forward on A; B stalls on the same EX match
      ex_wr = 8; rs = 8; rs_used = 1;
      #2;
      chk("t1_a_fwd_a", 32'(a_fa), 1);
      chk("t1_a_stalls", 32'(a_stalls), 0);
      chk("t1_a_flushs", 32'(a_flushs), 0);
      chk("t1_b_stalls", 32'(b_stalls), 5'b00011);
      chk("t1_b_flushs", 32'(b_flushs), 5'b00100);
      tick();
      chk("t1_a_fwd_cnt", 32'(a_cnt[4]), 1);
      chk("t1_b_dh_ex", b_cnt[1], 1);

      // load-use on rt with a shadowing MEM match
      idle();
      ex_is_load = 1; ex_wr = 9; mem_wr = 9; rt = 9; rt_used = 1;
      #2;
      chk("t2_a_fwd_b", 32'(a_fb), 0);
      chk("t2_a_stalls", 32'(a_stalls), 5'b00011);
      chk("t2_a_flushs", 32'(a_flushs), 5'b00100);
      tick();
      chk("t2_a_load_use", 32'(a_cnt[3]), 1);
      chk("t2_a_dh_ex", 32'(a_cnt[1]), 1);
      chk("t2_a_stall_cyc", 32'(a_cnt[8]), 1);
      chk("t2_a_fwd_cnt", 32'(a_cnt[4]), 1);

      // MEM match held two cycles
      idle();
      mem_wr = 3; rs = 3; rs_used = 1;
      #2;
      chk("t3_b_stalls0", 32'(b_stalls), 5'b00011);
      chk("t3_a_fwd_a", 32'(a_fa), 2);
      tick();
      chk("t3_b_stalls1", 32'(b_stalls), 5'b00011);
      tick();
      chk("t3_b_dh_mem", b_cnt[2], 2);
      chk("t3_b_dh", b_cnt[0], 4);
      chk("t3_a_fwd_cnt", 32'(a_cnt[4]), 3);

      // register 0 never hazards
      idle();
      rs = 0; rs_used = 1; ex_wr = 0;
      #2;
      chk("r0_b_stalls", 32'(b_stalls), 0);
      chk("r0_a_fwd_a", 32'(a_fa), 0);
      tick();

      // WB match: A forwards from WB, B does nothing
      idle();
      wb_wr = 5; rt = 5; rt_used = 1;
      #2;
      chk("wb_a_fwd_b", 32'(a_fb), 3);
      chk("wb_b_stalls", 32'(b_stalls), 0);
      chk("wb_b_fwd_b", 32'(b_fb), 0);
      tick();
      chk("wb_a_fwd_cnt", 32'(a_cnt[4]), 4);

      // jump with concurrent data match, then a branch during FLUSH
      idle();
      mem_wr = 3; rs = 3; rs_used = 1; pc_inc = PC_JMP;
      #2;
      chk("j1_b_flushs", 32'(b_flushs), 5'b00110);
      chk("j1_b_stalls", 32'(b_stalls), 0);
      chk("j1_a_flushs", 32'(a_flushs), 5'b00110);
      chk("j1_a_fwd_a", 32'(a_fa), 0);
      tick();
      pc_inc = PC_BR;
      #2;
      chk("j2_b_flushs", 32'(b_flushs), 5'b00010);
      chk("j2_b_stalls", 32'(b_stalls), 0);
      chk("j2_a_flushs", 32'(a_flushs), 5'b00110);
      tick();
      pc_inc = PC_NRM;
      #2;
      chk("j3_b_flushs", 32'(b_flushs), 5'b00010);
      chk("j3_b_stalls", 32'(b_stalls), 0);
      chk("j3_a_fwd_a", 32'(a_fa), 2);
      tick();
      chk("j4_b_stalls", 32'(b_stalls), 5'b00011);
      chk("j4_b_flushs", 32'(b_flushs), 5'b00100);
      chk("j4_b_ctrl", b_cnt[5], 1);
      chk("j4_b_jump", b_cnt[7], 1);
      chk("j4_b_branch", b_cnt[6], 0);
      chk("j4_b_dh", b_cnt[0], 4);
      chk("j4_a_ctrl", 32'(a_cnt[5]), 2);
      chk("j4_a_branch", 32'(a_cnt[6]), 1);
      chk("j4_a_fwd_cnt", 32'(a_cnt[4]), 5);
      tick();
      chk("j5_b_dh_mem", b_cnt[2], 3);

      // saturate A forward counter (6 + 20 > 15)
      idle();
      ex_wr = 8; rs = 8; rs_used = 1;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_a_fwd_cnt", 32'(a_cnt[4]), 15);
      chk("sat_b_dh", b_cnt[0], 25);

      // freeze with load-use events
      cnt_freeze = 1; ex_is_load = 1;
      #2;
      chk("frz_a_stalls", 32'(a_stalls), 5'b00011);
      for (int i = 0; i < 3; i++) tick();
      chk("frz_a_load_use", 32'(a_cnt[3]), 1);
      chk("frz_a_stall_cyc", 32'(a_cnt[8]), 1);
      chk("frz_a_fwd_cnt", 32'(a_cnt[4]), 15);
      chk("frz_b_dh", b_cnt[0], 25);

      // clear beats freeze
      cnt_clr = 1;
      tick();
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("clr_a_cnt%0d", i), 32'(a_cnt[i]), 0);
         chk($sformatf("clr_b_cnt%0d", i), b_cnt[i], 0);
      end
      cnt_clr = 0; cnt_freeze = 0;

      // async reset in the middle of FLUSH
      idle();
      pc_inc = PC_JMP;
      tick();
      pc_inc = PC_NRM;
      #1;
      chk("mf_b_flushs", 32'(b_flushs), 5'b00010);
      chk("mf_b_ctrl", b_cnt[5], 1);
      clr_n = 0;
      #1;
      chk("mf_rst_b_flushs", 32'(b_flushs), 0);
      for (int i = 0; i < 9; i++)
         chk($sformatf("mf_rst_b_cnt%0d", i), b_cnt[i], 0);
      #1;
      clr_n = 1;
      #1;
      chk("mf_post_b_flushs", 32'(b_flushs), 0);
      tick();
      chk("mf_run_b_flushs", 32'(b_flushs), 0);
      chk("mf_run_b_ctrl", b_cnt[5], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
